pucch_lprs_gen: RTL and testbench

PUCCH_LPRS_GEN -- requirements
Module: pucch_lprs_gen

---
 rtl/pucch_lprs_gen_if.sv | 33 +++
 rtl/pucch_lprs_gen.sv | 163 ++++++++++++++++
 tb/tb_pucch_lprs_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pucch_lprs_gen_if.sv
// Bus between the PUCCH low-PAPR sequence generator and its surroundings:
// start/parameter request, the external base-sequence phase lookup, and
// the valid/ready sample stream.
interface pucch_lprs_gen_if #(
  parameter int DW = 16
);
  logic                 i_start;
  logic [4:0]           i_u;
  logic [3:0]           i_m_cs;
  logic [4:0]           o_bs_u;
  logic [3:0]           o_bs_n;
  logic [15:0]          i_bs_phase24;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [DW-1:0] o_re;
  logic signed [DW-1:0] o_im;
  logic [3:0]           o_n;
  logic                 o_last;
  logic                 o_busy;
  logic                 o_done;

  // Generator side
  modport slave (
    input  i_start, i_u, i_m_cs, i_bs_phase24, i_ready,
    output o_bs_u, o_bs_n, o_valid, o_re, o_im, o_n, o_last, o_busy, o_done
  );

  // Requester / consumer side
  modport master (
    output i_start, i_u, i_m_cs, i_bs_phase24, i_ready,
    input  o_bs_u, o_bs_n, o_valid, o_re, o_im, o_n, o_last, o_busy, o_done
  );
endinterface

// File: rtl/pucch_lprs_gen.sv
// PUCCH length-12 low-PAPR sequence generator. On start, streams the 12
// samples exp(j*2*pi*p/24) where p = base phase + n * 2 * m_cs (mod 24).
// The base phase comes from an external combinational lookup addressed by
// o_bs_u/o_bs_n; the cyclic shift is applied with an accumulator.
module pucch_lprs_gen #(
  parameter int DW = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  pucch_lprs_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  // Quarter-wave cos table at 15 degree steps, Q1.14 for a 16-bit sample.
  localparam int QW16 [7] = '{16384, 15826, 14189, 11585, 8192, 4240, 0};

  state_t               state_reg;
  logic [4:0]           u_reg;
  logic [4:0]           step_reg;   // (2*m_cs) mod 24, fixed per sequence
  logic [4:0]           acc_reg;    // shift phase of the next sample, 0..23
  logic [3:0]           cnt_reg;    // samples loaded so far, 0..12
  logic                 valid_reg;
  logic signed [DW-1:0] re_reg;
  logic signed [DW-1:0] im_reg;
  logic [3:0]           n_reg;
  logic                 last_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic signed [DW-1:0] qw_tab [7];

  // Rescale the 16-bit table to the configured sample width.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_qw
      if (DW >= 16) begin : g_up
        assign qw_tab[gi] = DW'(QW16[gi]) <<< (DW - 16);
      end else begin : g_dn
        assign qw_tab[gi] = DW'(QW16[gi] >>> (16 - DW));
      end
    end
  endgenerate

  // Fold a phase 0..23 onto the first quadrant: {negate, table index}.
  function automatic logic [3:0] fold(input logic [4:0] p);
    if (p <= 5'd6)       fold = {1'b0, p[2:0]};
    else if (p <= 5'd12) fold = {1'b1, 3'(5'd12 - p)};
    else if (p <= 5'd18) fold = {1'b1, 3'(p - 5'd12)};
    else                 fold = {1'b0, 3'(5'd24 - p)};
  endfunction

  logic [3:0]           cm_cs;
  logic [4:0]           step_new;
  logic [4:0]           acc_use;
  logic [4:0]           step_use;
  logic [5:0]           acc_sum;
  logic [4:0]           acc_next;
  logic [5:0]           ph_sum;
  logic [4:0]           p_cos;
  logic [5:0]           sin_sum;
  logic [4:0]           p_sin;
  logic [3:0]           f_cos;
  logic [3:0]           f_sin;
  logic signed [DW-1:0] re_val;
  logic signed [DW-1:0] im_val;
  logic                 load_run;
  logic                 hs_last;
  logic                 bs_hi_unused;

  // Sample phase, next accumulator value and table lookups for the sample being loaded.
  always_comb begin
    cm_cs    = (bus.i_m_cs >= 4'd12) ? (bus.i_m_cs - 4'd12) : bus.i_m_cs;
    step_new = {cm_cs, 1'b0};
    acc_use  = (state_reg == IDLE) ? 5'd0 : acc_reg;
    step_use = (state_reg == IDLE) ? step_new : step_reg;
    acc_sum  = {1'b0, acc_use} + {1'b0, step_use};
    acc_next = (acc_sum >= 6'd24) ? 5'(acc_sum - 6'd24) : acc_sum[4:0];
    ph_sum   = {1'b0, bus.i_bs_phase24[4:0]} + {1'b0, acc_use};
    if (ph_sum >= 6'd48)      p_cos = 5'(ph_sum - 6'd48);
    else if (ph_sum >= 6'd24) p_cos = 5'(ph_sum - 6'd24);
    else                      p_cos = ph_sum[4:0];
    // sin(x) = cos(x - 90 deg), i.e. phase + 18 (mod 24)
    sin_sum  = {1'b0, p_cos} + 6'd18;
    p_sin    = (sin_sum >= 6'd24) ? 5'(sin_sum - 6'd24) : sin_sum[4:0];
    f_cos    = fold(p_cos);
    f_sin    = fold(p_sin);
    re_val   = f_cos[3] ? -qw_tab[f_cos[2:0]] : qw_tab[f_cos[2:0]];
    im_val   = f_sin[3] ? -qw_tab[f_sin[2:0]] : qw_tab[f_sin[2:0]];
    load_run = (state_reg == RUN) && (cnt_reg < 4'd12) && (!valid_reg || bus.i_ready);
    hs_last  = valid_reg && bus.i_ready && last_reg;
  end

  assign bs_hi_unused = ^bus.i_bs_phase24[15:5];

  assign bus.o_bs_u  = (state_reg == RUN) ? u_reg : bus.i_u;
  assign bus.o_bs_n  = ((state_reg == RUN) && (cnt_reg < 4'd12)) ? cnt_reg : 4'd0;
  assign bus.o_valid = valid_reg;
  assign bus.o_re    = re_reg;
  assign bus.o_im    = im_reg;
  assign bus.o_n     = n_reg;
  assign bus.o_last  = last_reg;
  assign bus.o_busy  = busy_reg;
  assign bus.o_done  = done_reg;

  // Control FSM with the registered output stage; sample 0 loads on the start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      u_reg     <= '0;
      step_reg  <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      re_reg    <= '0;
      im_reg    <= '0;
      n_reg     <= '0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            u_reg     <= bus.i_u;
            step_reg  <= step_new;
            acc_reg   <= acc_next;
            cnt_reg   <= 4'd1;
            valid_reg <= 1'b1;
            re_reg    <= re_val;
            im_reg    <= im_val;
            n_reg     <= 4'd0;
            last_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (load_run) begin
            valid_reg <= 1'b1;
            re_reg    <= re_val;
            im_reg    <= im_val;
            n_reg     <= cnt_reg;
            last_reg  <= (cnt_reg == 4'd11);
            cnt_reg   <= cnt_reg + 4'd1;
            acc_reg   <= acc_next;
          end else if (valid_reg && bus.i_ready) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
          end
          if (hs_last) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pucch_lprs_gen.sv
// Self-checking bench for pucch_lprs_gen: a random base-sequence lookup
// table answers the DUT's phase requests, and expected samples are
// computed from the phase rule with real-valued cos/sin.
module tb_pucch_lprs_gen;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pucch_lprs_gen_if #(.DW(DW)) bus ();

  pucch_lprs_gen #(.DW(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] bs_tab [32][16];
  bit         bs_fixed = 1'b1;
  logic [4:0] bs_fixed_val = 5'd3;
  int         got_re [12];
  int         got_im [12];

  assign bus.i_bs_phase24 = bs_fixed ? {11'd0, bs_fixed_val} : {11'd0, bs_tab[bus.o_bs_u][bus.o_bs_n]};

  function automatic int bs_model(input int u, input int n);
    return bs_fixed ? int'(bs_fixed_val) : int'(bs_tab[u][n]);
  endfunction

  function automatic int ref_val(input int p, input bit want_sin);
    real a, v;
    a = 2.0 * 3.14159265358979 * real'(p) / 24.0;
    v = 16384.0 * (want_sin ? $sin(a) : $cos(a));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Start a sequence from the current negedge and follow it to its done pulse.
  task automatic run_seq(input logic [4:0] u, input logic [3:0] mcs, input int stall_pct, input bit poke);
    int m, k, cyc, p;
    bit stalled, rdy;
    logic signed [DW-1:0] e_re, e_im;
    logic [3:0] p_bsn;
    m = (int'(mcs) >= 12) ? int'(mcs) - 12 : int'(mcs);
    bus.i_u = u; bus.i_m_cs = mcs; bus.i_start = 1'b1; bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL latency: o_valid got %b want 1", bus.o_valid); end
    k = 0; cyc = 0; stalled = 1'b0; p_bsn = '0;
    while (k < 12 && cyc < 500) begin
      p = (bs_model(int'(u), k) + 2 * m * k) % 24;
      e_re = DW'(ref_val(p, 1'b0));
      e_im = DW'(ref_val(p, 1'b1));
      n_checks++;
      if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid k=%0d got %b want 1", k, bus.o_valid); end
      n_checks++;
      if (bus.o_n !== 4'(k)) begin n_fail++; $display("FAIL seq_n got %0d want %0d", bus.o_n, k); end
      n_checks++;
      if (bus.o_re !== e_re) begin n_fail++; $display("FAIL seq_re n=%0d got %0d want %0d", k, bus.o_re, e_re); end
      n_checks++;
      if (bus.o_im !== e_im) begin n_fail++; $display("FAIL seq_im n=%0d got %0d want %0d", k, bus.o_im, e_im); end
      n_checks++;
      if (bus.o_last !== (k == 11)) begin n_fail++; $display("FAIL seq_last n=%0d got %b want %b", k, bus.o_last, (k == 11)); end
      n_checks++;
      if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
        n_fail++; $display("FAIL seq_busy_done n=%0d got busy=%b done=%b want 1/0", k, bus.o_busy, bus.o_done);
      end
      n_checks++;
      if (bus.o_bs_u !== u) begin n_fail++; $display("FAIL seq_bs_u got %0d want %0d", bus.o_bs_u, u); end
      if (stalled) begin
        n_checks++;
        if (bus.o_bs_n !== p_bsn) begin n_fail++; $display("FAIL stall_bs_n got %0d want %0d", bus.o_bs_n, p_bsn); end
      end
      if (poke && cyc == 3) begin
        bus.i_start = 1'b1; bus.i_u = u ^ 5'd7; bus.i_m_cs = 4'((int'(mcs) + 5) % 12);
      end else if (poke && cyc == 4) begin
        bus.i_start = 1'b0; bus.i_u = u; bus.i_m_cs = mcs;
      end
      rdy = ($urandom_range(99) >= stall_pct);
      bus.i_ready = rdy;
      p_bsn = bus.o_bs_n;
      if (bus.o_valid && rdy) begin
        got_re[k] = int'(bus.o_re); got_im[k] = int'(bus.o_im);
        k++; stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_start = 1'b0;
    n_checks++;
    if (k != 12) begin n_fail++; $display("FAIL seq_timeout handshakes got %0d want 12", k); end
    n_checks++;
    if (bus.o_done !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL seq_end got done=%b valid=%b busy=%b want 1/0/0", bus.o_done, bus.o_valid, bus.o_busy);
    end
    $display("seq u=%0d m_cs=%0d stall=%0d%% cycles=%0d handshakes=%0d", u, mcs, stall_pct, cyc, k);
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0; bus.i_u = '0; bus.i_m_cs = '0; bus.i_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.o_valid, bus.o_last, bus.o_busy, bus.o_done} !== 4'b0 || bus.o_re !== '0 || bus.o_im !== '0
        || bus.o_n !== '0 || bus.o_bs_n !== '0) begin
      n_fail++; $display("FAIL reset_state got v=%b l=%b b=%b d=%b re=%0d im=%0d n=%0d bs_n=%0d want all 0",
        bus.o_valid, bus.o_last, bus.o_busy, bus.o_done, bus.o_re, bus.o_im, bus.o_n, bus.o_bs_n);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle o_valid got %b want 0", bus.o_valid); end
    $display("reset checked");
  endtask

  task automatic test_const();
    bs_fixed = 1'b1; bs_fixed_val = 5'd3;
    run_seq(5'($urandom_range(29)), 4'd0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (got_re[i] != 11585 || got_im[i] != 11585) begin
        n_fail++; $display("FAIL const_val n=%0d got %0d/%0d want 11585/11585", i, got_re[i], got_im[i]);
      end
    end
  endtask

  task automatic test_phase_steps();
    int w_re [3];
    int w_im [3];
    bs_fixed = 1'b1; bs_fixed_val = 5'd3;
    run_seq(5'd4, 4'd1, 0, 1'b0);
    w_re = '{11585, 4240, -4240}; w_im = '{11585, 15826, 15826};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_re[i] != w_re[i] || got_im[i] != w_im[i]) begin
        n_fail++; $display("FAIL step_m1 n=%0d got %0d/%0d want %0d/%0d", i, got_re[i], got_im[i], w_re[i], w_im[i]);
      end
    end
    bs_fixed_val = 5'd21;
    run_seq(5'd17, 4'd6, 0, 1'b0);
    w_re = '{11585, -11585, 11585}; w_im = '{-11585, 11585, -11585};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_re[i] != w_re[i] || got_im[i] != w_im[i]) begin
        n_fail++; $display("FAIL step_m6 n=%0d got %0d/%0d want %0d/%0d", i, got_re[i], got_im[i], w_re[i], w_im[i]);
      end
    end
  endtask

  task automatic test_stall();
    bs_fixed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_seq(5'($urandom_range(29)), 4'($urandom_range(15)), 40, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bs_fixed = 1'b0;
    run_seq(5'($urandom_range(29)), 4'($urandom_range(11)), 20, 1'b1);
    run_seq(5'($urandom_range(29)), 4'd13, 0, 1'b0);
    run_seq(5'($urandom_range(29)), 4'($urandom_range(15)), 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bs_fixed = 1'b0;
    bus.i_u = 5'd9; bus.i_m_cs = 4'd5; bus.i_start = 1'b1; bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_n !== 4'(i)) begin
        n_fail++; $display("FAIL mid_pre n=%0d got valid=%b n=%0d", i, bus.o_valid, bus.o_n);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_valid, bus.o_last, bus.o_busy, bus.o_done} !== 4'b0 || bus.o_re !== '0 || bus.o_im !== '0
        || bus.o_n !== '0 || bus.o_bs_n !== '0) begin
      n_fail++; $display("FAIL mid_async got v=%b l=%b b=%b d=%b re=%0d im=%0d n=%0d want all 0",
        bus.o_valid, bus.o_last, bus.o_busy, bus.o_done, bus.o_re, bus.o_im, bus.o_n);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_quiet got valid=%b busy=%b want 0/0", bus.o_valid, bus.o_busy);
      end
    end
    $display("reset mid-sequence checked");
    run_seq(5'd9, 4'd5, 0, 1'b0);
  endtask

  initial begin
    for (int u = 0; u < 32; u++)
      for (int n = 0; n < 16; n++)
        bs_tab[u][n] = 5'(3 + 6 * $urandom_range(3));
    test_reset();
    test_const();
    test_phase_steps();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
